// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue controller sitting between the execute stage and a
// 32-bit ALU. Accepts one op at a time, holds the ALU inputs stable for the
// op's latency, returns Y/flags over a response handshake and owns HI/LO.
// Optional feature macro: ALU_BACK2BACK_EN (accept a new request in the same
// cycle the previous response is consumed).
module alu_op_sequencer #(
    parameter int         MULT_CYCLES = 4,
    parameter int         DIV_CYCLES  = 8,
    parameter logic [3:0] OP_MULT     = 4'b0001,
    parameter logic [3:0] OP_DIV      = 4'b0010
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [1:0]  req_sign,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [3:0]  alu_op,
    output logic [1:0]  alu_sign,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    input  logic [31:0] alu_y,
    input  logic [31:0] alu_hi,
    input  logic [31:0] alu_lo,
    input  logic [3:0]  alu_flags,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_y,
    output logic [3:0]  rsp_flags,
    output logic        rsp_dz,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy
);

    // Counter only ever holds LAT-1, so it needs enough bits for MAX_LAT-1.
    localparam int MAX_LAT = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    logic [CW-1:0]  count;
    logic           accept;
    logic           issue_dz;
    logic [CW-1:0]  issue_cnt;
    logic           hilo_op;

    // Request side is open in IDLE, and optionally while the response drains.
`ifdef ALU_BACK2BACK_EN
    assign req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
`else
    assign req_ready = (state == IDLE);
`endif

    assign busy     = (state != IDLE);
    assign accept   = req_valid && req_ready;
    assign issue_dz = (req_op == OP_DIV) && (req_b == 32'd0);
    assign hilo_op  = (alu_op == OP_MULT) || (alu_op == OP_DIV);

    // Initial counter value (LAT-1) for the op being accepted.
    always_comb begin
        issue_cnt = '0;
        if (req_op == OP_MULT) begin
            issue_cnt = CW'(MULT_CYCLES - 1);
        end else if (req_op == OP_DIV) begin
            issue_cnt = CW'(DIV_CYCLES - 1);
        end
    end

    // Sequencer FSM: issue, hold for latency, capture and hand back result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            alu_op    <= '0;
            alu_sign  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_y     <= '0;
            rsp_flags <= '0;
            rsp_dz    <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else if (accept) begin
            // Accept only happens in IDLE or while a response is consumed,
            // so a new issue fully defines the next state.
            if (issue_dz) begin
                // Divide by zero never reaches the ALU; answer immediately.
                state     <= RESP;
                rsp_valid <= 1'b1;
                rsp_y     <= '0;
                rsp_flags <= '0;
                rsp_dz    <= 1'b1;
            end else begin
                state     <= EXEC;
                rsp_valid <= 1'b0;
                count     <= issue_cnt;
                alu_op    <= req_op;
                alu_sign  <= req_sign;
                alu_a     <= req_a;
                alu_b     <= req_b;
            end
        end else begin
            case (state)
                EXEC: begin
                    if (count != '0) begin
                        count <= count - 1'b1;
                    end else begin
                        rsp_y     <= alu_y;
                        rsp_flags <= alu_flags;
                        rsp_dz    <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                        if (hilo_op) begin
                            hi <= alu_hi;
                            lo <= alu_lo;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed bench for alu_op_sequencer with a small
// behavioural ALU model. Handles both builds of ALU_BACK2BACK_EN.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [1:0]  req_sign;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  alu_op;
    logic [1:0]  alu_sign;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_y;
    logic [31:0] alu_hi;
    logic [31:0] alu_lo;
    logic [3:0]  alu_flags;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_y;
    logic [3:0]  rsp_flags;
    logic        rsp_dz;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    alu_op_sequencer #(
        .MULT_CYCLES(4),
        .DIV_CYCLES (8),
        .OP_MULT    (4'b0001),
        .OP_DIV     (4'b0010)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_sign  (req_sign),
        .req_a     (req_a),
        .req_b     (req_b),
        .alu_op    (alu_op),
        .alu_sign  (alu_sign),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_y     (alu_y),
        .alu_hi    (alu_hi),
        .alu_lo    (alu_lo),
        .alu_flags (alu_flags),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_y     (rsp_y),
        .rsp_flags (rsp_flags),
        .rsp_dz    (rsp_dz),
        .hi        (hi),
        .lo        (lo),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: 0 add, 1 multiply, 2 divide, otherwise subtract.
    // flags = {y==0, y[31], a[0], b[0]}.
    logic [63:0] prod;
    always_comb begin
        prod   = 64'(alu_a) * 64'(alu_b);
        alu_hi = '0;
        alu_lo = '0;
        case (alu_op)
            4'd0: alu_y = alu_a + alu_b;
            4'd1: begin
                alu_hi = prod[63:32];
                alu_lo = prod[31:0];
                alu_y  = prod[31:0];
            end
            4'd2: begin
                if (alu_b != 32'd0) begin
                    alu_lo = alu_a / alu_b;
                    alu_hi = alu_a % alu_b;
                end
                alu_y = alu_lo;
            end
            default: alu_y = alu_a - alu_b;
        endcase
        alu_flags = {(alu_y == 32'd0), alu_y[31], alu_a[0], alu_b[0]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single edge (E0).
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op    = op;
        req_sign  = 2'b00;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        req_a     = 32'hDEAD_BEEF;
        req_b     = 32'h1234_5678;
        $display("issue op=%0d a=%0d b=%0d", op, a, b);
    endtask

    // Count edges after E0 until rsp_valid rises (bounded).
    task automatic wait_rsp(input string tag, input int lat);
        int n = 0;
        while (!rsp_valid && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'(lat));
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = '0;
        req_sign  = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);

        // Short op: 1 + 1
        issue(4'd0, 32'd1, 32'd1);
        check("short_alu_a", alu_a, 32'd1);
        check("short_alu_b", alu_b, 32'd1);
        check("short_valid_e0", 32'(rsp_valid), 32'd0);
        wait_rsp("short_lat", 1);
        check("short_y", rsp_y, 32'd2);
        check("short_flags", 32'(rsp_flags), 32'h3);
        check("short_hi", hi, 32'd0);
        check("short_lo", lo, 32'd0);
        consume();
        check("short_done_valid", 32'(rsp_valid), 32'd0);
        check("short_done_ready", 32'(req_ready), 32'd1);
        $display("short op done y=%0d", rsp_y);

        // Multiply 5 * 2 (req_* scrambled after accept must not matter)
        issue(4'd1, 32'd5, 32'd2);
        check("mult_ready_busy", 32'(req_ready), 32'd0);
        wait_rsp("mult_lat", 4);
        check("mult_alu_a_held", alu_a, 32'd5);
        check("mult_y", rsp_y, 32'd10);
        check("mult_flags", 32'(rsp_flags), 32'h2);
        check("mult_lo", lo, 32'd10);
        check("mult_hi", hi, 32'd0);
        consume();
        $display("mult done hi=%0d lo=%0d", hi, lo);

        // Divide by zero: immediate response, ALU and HI/LO untouched
        issue(4'd2, 32'd8, 32'd0);
        check("dz_valid_e0", 32'(rsp_valid), 32'd1);
        tick();
        check("dz_valid_e1", 32'(rsp_valid), 32'd1);
        check("dz_flag", 32'(rsp_dz), 32'd1);
        check("dz_y", rsp_y, 32'd0);
        check("dz_flags", 32'(rsp_flags), 32'd0);
        check("dz_alu_b_kept", alu_b, 32'd2);
        check("dz_hi", hi, 32'd0);
        check("dz_lo", lo, 32'd10);
        consume();
        $display("div-by-zero done dz=%0d", rsp_dz);

        // Divide 8 / 3
        issue(4'd2, 32'd8, 32'd3);
        wait_rsp("div_lat", 8);
        check("div_y", rsp_y, 32'd2);
        check("div_dz", 32'(rsp_dz), 32'd0);
        check("div_flags", 32'(rsp_flags), 32'h1);
        check("div_lo", lo, 32'd2);
        check("div_hi", hi, 32'd2);
        consume();
        $display("div done hi=%0d lo=%0d", hi, lo);

        // Backpressure on a short op 7 + 9, with a competing request pending
        issue(4'd0, 32'd7, 32'd9);
        wait_rsp("bp_lat", 1);
        req_op    = 4'd0;
        req_a     = 32'd3;
        req_b     = 32'd4;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_y_stable", rsp_y, 32'd16);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
`ifdef ALU_BACK2BACK_EN
        check("b2b_ready_comb", 32'(req_ready), 32'd1);
        tick();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        check("b2b_valid_low", 32'(rsp_valid), 32'd0);
        check("b2b_alu_a", alu_a, 32'd3);
        wait_rsp("b2b_lat", 1);
`else
        check("nob2b_ready", 32'(req_ready), 32'd0);
        tick();
        rsp_ready = 1'b0;
        check("nob2b_idle", 32'(busy), 32'd0);
        check("nob2b_valid_low", 32'(rsp_valid), 32'd0);
        tick();
        req_valid = 1'b0;
        check("nob2b_alu_a", alu_a, 32'd3);
        wait_rsp("nob2b_lat", 1);
`endif
        check("next_y", rsp_y, 32'd7);
        consume();
        $display("backpressure done y=%0d", rsp_y);

        // Async reset mid-divide with counter at 3
        issue(4'd2, 32'd100, 32'd7);
        tick();
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_alu_a", alu_a, 32'd0);
        check("arst_alu_b", alu_b, 32'd0);
        check("arst_alu_op", 32'(alu_op), 32'd0);
        check("arst_rsp_y", rsp_y, 32'd0);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", 32'(req_ready), 32'd1);
        check("post_rst_hi", hi, 32'd0);
        check("post_rst_lo", lo, 32'd0);
        tick();
        check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        $display("async reset done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
